// File: rtl/fir_filter_pkg.sv
// Shared constants and the controller state type for the time-multiplexed FIR filter.
package fir_filter_pkg;

  localparam int DATABITS   = 16;
  localparam int ACCBITS    = 40;
  localparam int CLK_PERIOD = 10;

  localparam int TAPS_DEF  = 32;
  localparam int RDLAT_DEF = 1;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    LOAD  = 3'd4,
    OUT   = 3'd5
  } fir_state_t;

endpackage

// File: rtl/fir_mac_ctrl_if.sv
// Input-sample and output-result valid/ready handshakes of the FIR controller.
// The controller takes the slave view; the producer/consumer side takes the master view.
interface fir_mac_ctrl_if;

  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    input  in_ready,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_valid,
    output in_ready,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/fir_mac_ctrl_mod_counter.sv
// Modulo-N up/down counter with synchronous clear and load.
// Wrapping is done by explicit compare, so N need not be a power of two.
module mod_counter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] MAX = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear beats load beats step; wrap_o flags a step across the N-1/0 boundary.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (inc_i) begin
      if (cnt_q == MAX) begin
        cnt_d  = '0;
        wrap_o = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else if (dec_i) begin
      if (cnt_q == '0) begin
        cnt_d  = MAX;
        wrap_o = 1'b1;
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fir_mac_ctrl.sv
// Sequencing controller for a time-multiplexed FIR: zero-fills the sample RAM,
// accepts samples, walks the MAC over all taps, strobes saturation and hands
// the result downstream. Control and addresses only, no datapath.
module fir_mac_ctrl
  import fir_filter_pkg::*;
#(
  parameter int  TAPS  = TAPS_DEF,
  parameter int  RDLAT = RDLAT_DEF,
  localparam int ADDRW = $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  fir_mac_ctrl_if.slave    hs,
  output logic             samp_we_o,
  output logic             samp_zero_o,
  output logic [ADDRW-1:0] samp_waddr_o,
  output logic [ADDRW-1:0] samp_raddr_o,
  output logic [ADDRW-1:0] coef_raddr_o,
  output logic             acc_clear_o,
  output logic             acc_en_o,
  output logic             sat_load_o,
  output logic             busy_o
);

  fir_state_t       state_q, state_d;
  logic             run_q;
  logic [1:0]       drain_q, drain_d;

  logic [ADDRW-1:0] wp_s, k_s, rp_s, init_s;
  logic             k_wrap_s, init_wrap_s;
  logic             wp_wrap_unused_s, rp_wrap_unused_s;
  logic             hs_in_s;
  logic             issue_en_s, issue_clr_s;
  logic             in_ready_s, out_valid_s;

  // run_q stays low while in reset so the INIT outputs only appear once the clock runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign hs_in_s = (state_q == IDLE) && hs.in_valid;

  // Write pointer: next free slot of the circular sample buffer.
  mod_counter #(.N(TAPS), .W(ADDRW)) u_wp (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .ld_i(1'b0), .ld_val_i('0),
    .inc_i(hs_in_s), .dec_i(1'b0), .cnt_o(wp_s), .wrap_o(wp_wrap_unused_s)
  );

  // Tap index k, also the coefficient address.
  mod_counter #(.N(TAPS), .W(ADDRW)) u_k (
    .clk(clk), .rst_n(rst_n), .clr_i(hs_in_s), .ld_i(1'b0), .ld_val_i('0),
    .inc_i(state_q == MAC), .dec_i(1'b0), .cnt_o(k_s), .wrap_o(k_wrap_s)
  );

  // Read pointer: starts at the newest sample and walks backwards, i.e. newest - k mod TAPS.
  mod_counter #(.N(TAPS), .W(ADDRW)) u_rp (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .ld_i(hs_in_s), .ld_val_i(wp_s),
    .inc_i(1'b0), .dec_i(state_q == MAC), .cnt_o(rp_s), .wrap_o(rp_wrap_unused_s)
  );

  // Zero-fill sweep address.
  mod_counter #(.N(TAPS), .W(ADDRW)) u_init (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .ld_i(1'b0), .ld_val_i('0),
    .inc_i((state_q == INIT) && run_q), .dec_i(1'b0), .cnt_o(init_s), .wrap_o(init_wrap_s)
  );

  // State and drain-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      INIT: begin
        if (run_q && init_wrap_s) begin
          state_d = IDLE;
        end else begin
          state_d = INIT;
        end
      end
      IDLE: begin
        if (hs_in_s) begin
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        if (k_wrap_s) begin
          drain_d = 2'd0;
          if (RDLAT == 0) begin
            state_d = LOAD;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          state_d = MAC;
        end
      end
      DRAIN: begin
        if (drain_q == 2'(RDLAT - 1)) begin
          state_d = LOAD;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      LOAD: state_d = OUT;
      OUT: begin
        if (hs.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Output decode; the IDLE write is combinational from the input handshake.
  always_comb begin
    samp_we_o    = 1'b0;
    samp_zero_o  = 1'b0;
    samp_waddr_o = '0;
    samp_raddr_o = '0;
    coef_raddr_o = '0;
    sat_load_o   = 1'b0;
    busy_o       = 1'b0;
    in_ready_s   = 1'b0;
    out_valid_s  = 1'b0;
    issue_en_s   = 1'b0;
    issue_clr_s  = 1'b0;
    case (state_q)
      INIT: begin
        samp_we_o    = run_q;
        samp_zero_o  = run_q;
        samp_waddr_o = run_q ? init_s : '0;
        busy_o       = run_q;
      end
      IDLE: begin
        in_ready_s   = 1'b1;
        samp_we_o    = hs_in_s;
        samp_waddr_o = hs_in_s ? wp_s : '0;
      end
      MAC: begin
        busy_o       = 1'b1;
        coef_raddr_o = k_s;
        samp_raddr_o = rp_s;
        issue_en_s   = 1'b1;
        issue_clr_s  = (k_s == '0);
      end
      DRAIN: busy_o = 1'b1;
      LOAD: begin
        busy_o     = 1'b1;
        sat_load_o = 1'b1;
      end
      OUT: begin
        busy_o      = 1'b1;
        out_valid_s = 1'b1;
      end
      default: busy_o = 1'b1;
    endcase
  end

  assign hs.in_ready  = in_ready_s;
  assign hs.out_valid = out_valid_s;

  // MAC strobes travel through a delay line so they line up with the memory read data.
  generate
    if (RDLAT == 0) begin : g_nodly
      assign acc_en_o    = issue_en_s;
      assign acc_clear_o = issue_clr_s;
    end else begin : g_dly
      logic [RDLAT-1:0] en_dly_q;
      logic [RDLAT-1:0] clr_dly_q;

      // Shift the issued strobes by RDLAT cycles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          en_dly_q  <= '0;
          clr_dly_q <= '0;
        end else begin
          en_dly_q[0]  <= issue_en_s;
          clr_dly_q[0] <= issue_clr_s;
          for (int i = 1; i < RDLAT; i++) begin
            en_dly_q[i]  <= en_dly_q[i-1];
            clr_dly_q[i] <= clr_dly_q[i-1];
          end
        end
      end

      assign acc_en_o    = en_dly_q[RDLAT-1];
      assign acc_clear_o = clr_dly_q[RDLAT-1];
    end
  endgenerate

endmodule

// File: doc/fir_mac_ctrl.md
Name: fir_mac_ctrl

Overview:
Sequencing controller for a time-multiplexed FIR filter. It owns one multiply-accumulate unit, the circular sample RAM and the coefficient ROM.
- Accepts one input sample per valid/ready handshake and writes it into the sample RAM.
- Steps the MAC through all taps, then strobes the existing saturation stage (ACCBITS to DATABITS).
- Presents the result with a valid/ready handshake.
- Contains no datapath arithmetic, only control and addresses.

Parameters:
TAPS, 32, number of filter taps (any value >= 2; need not be a power of two)
RDLAT, 1, read latency in cycles of the sample RAM and coefficient ROM (0..3)
ADDRW, $clog2(TAPS), address width (derived; not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  controller can accept a sample
out_valid  out  1  saturated result valid
out_ready  in  1  downstream accepts result
samp_we  out  1  sample RAM write enable
samp_zero  out  1  selects zero as sample RAM write data (init sweep)
samp_waddr  out  ADDRW  sample RAM write address
samp_raddr  out  ADDRW  sample RAM read address
coef_raddr  out  ADDRW  coefficient ROM read address
acc_clear  out  1  MAC loads the product instead of adding it (first tap)
acc_en  out  1  MAC update strobe
sat_load  out  1  capture saturated accumulator into output register
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. Reset forces state INIT, write pointer wp=0, tap counter k=0 and the init counter to 0.
- Reset values of outputs: all outputs are 0 during reset, including in_ready and out_valid. Addresses are 0.
- INIT sweep after reset:
  - For TAPS cycles: samp_we=1, samp_zero=1, samp_waddr = init counter 0..TAPS-1. in_ready=0.
  - After the last write, go to IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready (cycle C0): samp_we=1 and samp_waddr=wp in the same cycle (combinational from the handshake).
  - Latch newest=wp. Advance wp modulo TAPS (TAPS-1 wraps to 0). Go to MAC with k=0.
- MAC (TAPS cycles, C1..C_TAPS):
  - coef_raddr=k.
  - samp_raddr = (newest - k) mod TAPS, with wrap below 0 to TAPS-1.
  - k increments each cycle. After k=TAPS-1, go to DRAIN.
- Accumulator strobes:
  - acc_en and acc_clear are issued through an RDLAT-deep delay line aligned with the read data.
  - acc_clear accompanies tap 0 only.
  - acc_en is high for exactly TAPS cycles, C1+RDLAT .. C_TAPS+RDLAT.
- DRAIN: RDLAT cycles; skipped when RDLAT=0. Then go to LOAD.
- LOAD: sat_load=1 for one cycle, C_TAPS+RDLAT+1. Go to OUT.
- OUT:
  - out_valid=1 from C_TAPS+RDLAT+2 and held until out_ready=1.
  - On the out handshake, go to IDLE. in_ready rises the following cycle.
- Sample acceptance: in_ready=0 in all non-IDLE states. in_valid is ignored there and the sample is neither written nor dropped silently; the source must hold it.
- Latency: from the input handshake to the first out_valid cycle is TAPS+RDLAT+2 cycles. Throughput is one sample per TAPS+RDLAT+3 cycles when out_ready is held high.
- Simultaneous out_ready and in_valid in OUT: only the output completes. The input is accepted in the next cycle (IDLE).
- Reset mid-operation (any state): return immediately to INIT. The partial result is discarded, no out_valid pulse occurs, and the init sweep is repeated.
- Address arithmetic is unsigned ADDRW-bit with explicit compare-and-wrap. There is no reliance on power-of-two truncation.

Decomposition:
- fir_filter_pkg receives:
  - the state enum typedef (INIT, IDLE, MAC, DRAIN, LOAD, OUT);
  - constants TAPS_DEF=32 and RDLAT_DEF=1, beside the existing DATABITS/ACCBITS/CLK_PERIOD.
- One sub-module, mod_counter: a parameterised modulo-N up/down counter with load, clear and wrap. It is instantiated for wp, k and the init counter, and its decrement form is used for the read pointer.

Test Plan:
- Use TAPS=4, RDLAT=1 throughout.
- Reset release: samp_we=1 and samp_zero=1 for 4 cycles with waddr 0,1,2,3; in_ready first 1 in cycle 5; all other outputs 0.
- Single sample with out_ready=1: handshake at C0 writes waddr 0. samp_raddr sequence 0,3,2,1 with coef_raddr 0,1,2,3. acc_en C2..C5, acc_clear at C2 only, sat_load at C6, out_valid at C7 for one cycle.
- Five consecutive samples: waddr 0,1,2,3,0, with wp wrapping. Fifth frame samp_raddr is 0,3,2,1. Sample period is 8 cycles.
- Backpressure: out_ready=0 for 10 cycles in OUT means out_valid is held for 10 cycles and in_ready=0 with in_valid=1. After the out_ready pulse, the sample is accepted exactly one cycle later.
- Reset asserted during MAC at k=2: outputs go to 0 asynchronously. After release, the INIT sweep repeats and no out_valid appears.
- RDLAT=0 variant: the acc_en window starts at C1 and out_valid starts at C6.
